axi4_m2s_read_arbiter: RTL and testbench
========================================

# axi4_m2s_read_arbiter

Round-robin arbiter connecting NR_OF_MASTERS_P AXI4 read masters to one AXI4 slave read port (AR and R channels). It is the read-side companion to the team's write-channel many-to-one arbiter. The granted master gets exactly one AR transfer, and its whole R burst is routed back to it before the next grant. Bursts are forced to INCR.

## Interface
- AXI_ID_WIDTH_P, 3, ID width on master and slave ports (no ID extension).
- AXI_ADDR_WIDTH_P, 32, address width.
- AXI_DATA_WIDTH_P, 32, data width; power of two, ≥8.
- NR_OF_MASTERS_P, 4, number of masters; ≥2.
- **Clock and reset: one clock; reset is synchronous and active-low.**
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- mst_arid  in  [0:N-1][ID-1:0]  per-master AR ID.
- mst_araddr  in  [0:N-1][ADDR-1:0]  per-master AR address.
- mst_arlen  in  [0:N-1][7:0]  per-master burst length minus 1.
- mst_arvalid  in  [0:N-1]  per-master AR valid.
- mst_arready  out  [0:N-1]  per-master AR ready.
- mst_rid  out  ID  broadcast of slv_rid.
- mst_rdata  out  DATA  broadcast of slv_rdata.
- mst_rresp  out  2  broadcast of slv_rresp.
- mst_rlast  out  1  broadcast of slv_rlast.
- mst_rvalid  out  [0:N-1]  per-master R valid; only the granted bit can be 1.
- mst_rready  in  [0:N-1]  per-master R ready.
- slv_arid, slv_araddr, slv_arlen  out  ID/ADDR/8  muxed from the granted master.
- slv_arsize  out  3  constant $clog2(AXI_DATA_WIDTH_P/8).
- slv_arburst  out  2  constant 2'b01 (INCR).
- slv_arlock, slv_arcache, slv_arprot, slv_arqos  out  1/4/3/4  constant 0.
- slv_arvalid  out  1  AR valid toward the slave.
- slv_arready  in  1  AR ready from the slave.
- slv_rid, slv_rdata, slv_rresp, slv_rlast, slv_rvalid  in  R channel from the slave.
- slv_rready  out  1  R ready toward the slave.
- rd_id_err  out  1  one-cycle pulse on an R beat with an unexpected ID (see Configuration).

## Operation
- FSM states:
  - RD_IDLE_E: search for a requester.
  - RD_AR_E: address phase.
  - RD_DATA_E: data phase.
- Registers:
  - rr_ptr: next master with top priority.
  - sel: granted master index.
  - state.
  - arid_q (macro only).
- RD_IDLE_E:
  - Grant goes to the first master i with mst_arvalid[i]=1, scanning rr_ptr, rr_ptr+1, … with wrap at N-1→0.
  - On grant: sel<=i, rr_ptr<=(i==N-1)?0:i+1, state<=RD_AR_E.
  - No requester: rr_ptr unchanged.
- RD_AR_E:
  - Pass-through: slv_arvalid=mst_arvalid[sel]; mst_arready[sel]=slv_arready; slv_ar* fields muxed by sel.
  - On slv_arvalid&&slv_arready: state<=RD_DATA_E.
- RD_DATA_E:
  - Pass-through: mst_rvalid[sel]=slv_rvalid; slv_rready=mst_rready[sel].
  - On slv_rvalid&&slv_rready&&slv_rlast: state<=RD_IDLE_E.
- Outside each channel's own state, the following are forced to 0: slv_arvalid, all mst_arready, slv_ar* muxed fields, all mst_rvalid, slv_rready.
- Slave R beats arriving outside RD_DATA_E are not accepted (slv_rready=0).
- No burst-length counting; termination is by slv_rlast only.

## Timing
- Reset values:
  - state=RD_IDLE_E, rr_ptr=0, sel=0, rd_id_err=0.
  - All valid/ready outputs 0; muxed AR fields 0.
- Grant latency: mst_arvalid sampled in RD_IDLE_E at cycle t → slv_arvalid=1 at cycle t+1.
- AR and R handshakes are combinational pass-through, adding zero cycles of latency.
- After the rlast handshake, one RD_IDLE_E cycle always precedes the next grant. Minimum gap is 2 cycles between an rlast handshake and the next slv_arvalid.
- Simultaneous requests: exactly one grant per RD_IDLE_E cycle. A master that deasserts arvalid before grant is skipped.
- Reset asserted mid-burst: the next cycle is in RD_IDLE_E with all outputs at reset values. An in-flight slave burst is abandoned; its handling is the system's responsibility.

## Configuration
- AXI4_M2S_RD_ARB_ID_CHECK_EN defined:
  - arid_q<=mst_arid[sel] on the AR handshake.
  - On each R handshake with slv_rid≠arid_q, rd_id_err=1 for the following cycle (registered pulse).
- Not defined: no arid_q register; rd_id_err tied to 0.

## Structure
- axi4_types_pkg holds AXI4_BURST_INCR_C (2'b01) and the AXI4 resp encodings.
- The FSM enum is local to the module.
- One sub-module, arb_rr_select (parameter N):
  - Inputs: request vector and rr_ptr.
  - Outputs: valid and granted index.
  - Purely combinational rotate-priority picker.

## Test plan
- Reset then single master 2, arlen=3, araddr=0x100:
  - slv_araddr=0x100, arburst=01, arsize=2 one cycle after arvalid.
  - 4 R beats reach only mst_rvalid[2].
  - Return to idle after rlast.
- All 4 masters request continuously, rr_ptr=0: grant order 0,1,2,3,0; each burst completes before the next slv_arvalid.
- Slave holds slv_arready=0 for 5 cycles: mst_arready[sel]=0 throughout and slv_arvalid stays 1; handshake occurs in the cycle slv_arready=1.
- Master deasserts mst_rready for 3 cycles mid-burst: slv_rready=0 in those cycles; no beat lost or duplicated.
- Reset pulse during beat 2 of an 8-beat burst: outputs return to reset values next cycle; a fresh request is then granted normally.
- Macro defined, granted arid=5, slave returns rid=6 on beat 0: rd_id_err=1 for exactly one cycle. Macro undefined: rd_id_err stays 0.

Source files
------------

// File: rtl/axi4_types_pkg.sv
// Shared AXI4 encodings used by the read-channel arbiter.
package axi4_types_pkg;

  localparam logic [1:0] AXI4_BURST_FIXED_C = 2'b00;
  localparam logic [1:0] AXI4_BURST_INCR_C  = 2'b01;
  localparam logic [1:0] AXI4_BURST_WRAP_C  = 2'b10;

  localparam logic [1:0] AXI4_RESP_OKAY_C   = 2'b00;
  localparam logic [1:0] AXI4_RESP_EXOKAY_C = 2'b01;
  localparam logic [1:0] AXI4_RESP_SLVERR_C = 2'b10;
  localparam logic [1:0] AXI4_RESP_DECERR_C = 2'b11;

endpackage

// File: rtl/arb_rr_select.sv
// Combinational rotate-priority picker: first set request at or after rr_ptr,
// wrapping from N-1 back to 0.
module arb_rr_select #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [0:N-1]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum       = {1'b0, rr_ptr} + (IW+1)'(gi);
      assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    end
  endgenerate

  // Scan from lowest priority upward so the highest-priority hit wins last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        valid = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/axi4_m2s_read_arbiter.sv
// Round-robin many-to-one AXI4 read arbiter; one AR plus its full R burst per grant.
// Optional R-ID checking is enabled by defining AXI4_M2S_RD_ARB_ID_CHECK_EN.
module axi4_m2s_read_arbiter
  import axi4_types_pkg::*;
#(
  parameter int AXI_ID_WIDTH_P   = 3,
  parameter int AXI_ADDR_WIDTH_P = 32,
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int NR_OF_MASTERS_P  = 4
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic [0:NR_OF_MASTERS_P-1][AXI_ID_WIDTH_P-1:0]     mst_arid,
  input  logic [0:NR_OF_MASTERS_P-1][AXI_ADDR_WIDTH_P-1:0]   mst_araddr,
  input  logic [0:NR_OF_MASTERS_P-1][7:0]                    mst_arlen,
  input  logic [0:NR_OF_MASTERS_P-1]                         mst_arvalid,
  output logic [0:NR_OF_MASTERS_P-1]                         mst_arready,
  output logic [AXI_ID_WIDTH_P-1:0]                          mst_rid,
  output logic [AXI_DATA_WIDTH_P-1:0]                        mst_rdata,
  output logic [1:0]                                         mst_rresp,
  output logic                                               mst_rlast,
  output logic [0:NR_OF_MASTERS_P-1]                         mst_rvalid,
  input  logic [0:NR_OF_MASTERS_P-1]                         mst_rready,
  output logic [AXI_ID_WIDTH_P-1:0]                          slv_arid,
  output logic [AXI_ADDR_WIDTH_P-1:0]                        slv_araddr,
  output logic [7:0]                                         slv_arlen,
  output logic [2:0]                                         slv_arsize,
  output logic [1:0]                                         slv_arburst,
  output logic                                               slv_arlock,
  output logic [3:0]                                         slv_arcache,
  output logic [2:0]                                         slv_arprot,
  output logic [3:0]                                         slv_arqos,
  output logic                                               slv_arvalid,
  input  logic                                               slv_arready,
  input  logic [AXI_ID_WIDTH_P-1:0]                          slv_rid,
  input  logic [AXI_DATA_WIDTH_P-1:0]                        slv_rdata,
  input  logic [1:0]                                         slv_rresp,
  input  logic                                               slv_rlast,
  input  logic                                               slv_rvalid,
  output logic                                               slv_rready,
  output logic                                               rd_id_err
);

  localparam int SEL_W = $clog2(NR_OF_MASTERS_P);

  typedef enum logic [1:0] {RD_IDLE_E, RD_AR_E, RD_DATA_E} rd_state_t;

  rd_state_t        state_reg, state_next;
  logic [SEL_W-1:0] rr_ptr_reg, sel_reg;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             ar_phase, r_phase, ar_hs, r_hs;

  arb_rr_select #(.N(NR_OF_MASTERS_P)) u_rr_select (
    .req    (mst_arvalid),
    .rr_ptr (rr_ptr_reg),
    .valid  (grant_valid),
    .idx    (grant_idx)
  );

  assign ar_phase    = (state_reg == RD_AR_E);
  assign r_phase     = (state_reg == RD_DATA_E);
  assign slv_arvalid = ar_phase && mst_arvalid[sel_reg];
  assign ar_hs       = slv_arvalid && slv_arready;
  assign slv_rready  = r_phase && mst_rready[sel_reg];
  assign r_hs        = slv_rvalid && slv_rready;

  genvar gi;
  generate
    for (gi = 0; gi < NR_OF_MASTERS_P; gi++) begin : g_mst
      assign mst_arready[gi] = ar_phase && (sel_reg == SEL_W'(gi)) && slv_arready;
      assign mst_rvalid[gi]  = r_phase && (sel_reg == SEL_W'(gi)) && slv_rvalid;
    end
  endgenerate

  assign slv_arid    = ar_phase ? mst_arid[sel_reg]   : '0;
  assign slv_araddr  = ar_phase ? mst_araddr[sel_reg] : '0;
  assign slv_arlen   = ar_phase ? mst_arlen[sel_reg]  : '0;
  assign slv_arsize  = 3'($clog2(AXI_DATA_WIDTH_P / 8));
  assign slv_arburst = AXI4_BURST_INCR_C;
  assign slv_arlock  = 1'b0;
  assign slv_arcache = 4'd0;
  assign slv_arprot  = 3'd0;
  assign slv_arqos   = 4'd0;

  assign mst_rid   = slv_rid;
  assign mst_rdata = slv_rdata;
  assign mst_rresp = slv_rresp;
  assign mst_rlast = slv_rlast;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RD_IDLE_E: if (grant_valid)       state_next = RD_AR_E;
      RD_AR_E:   if (ar_hs)             state_next = RD_DATA_E;
      RD_DATA_E: if (r_hs && slv_rlast) state_next = RD_IDLE_E;
      default:                          state_next = RD_IDLE_E;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= RD_IDLE_E;
      rr_ptr_reg <= '0;
      sel_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == RD_IDLE_E && grant_valid) begin
        sel_reg    <= grant_idx;
        rr_ptr_reg <= (grant_idx == SEL_W'(NR_OF_MASTERS_P - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end
  end

`ifdef AXI4_M2S_RD_ARB_ID_CHECK_EN
  logic [AXI_ID_WIDTH_P-1:0] arid_q_reg;
  logic                      rd_id_err_reg;

  // The error is a registered pulse, so it lands one cycle after the offending beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arid_q_reg    <= '0;
      rd_id_err_reg <= 1'b0;
    end else begin
      if (ar_hs) arid_q_reg <= mst_arid[sel_reg];
      rd_id_err_reg <= r_hs && (slv_rid != arid_q_reg);
    end
  end

  assign rd_id_err = rd_id_err_reg;
`else
  assign rd_id_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_m2s_read_arbiter.sv
// Scoreboard bench for axi4_m2s_read_arbiter: stimulus queues expected AR/R
// traffic, a negedge monitor pops and compares on each handshake.
module tb_axi4_m2s_read_arbiter;

  localparam int N   = 4;
  localparam int IDW = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic [0:N-1][IDW-1:0]   mst_arid;
  logic [0:N-1][AW-1:0]    mst_araddr;
  logic [0:N-1][7:0]       mst_arlen;
  logic [0:N-1]            mst_arvalid, mst_arready, mst_rvalid, mst_rready;
  logic [IDW-1:0]          mst_rid;
  logic [DW-1:0]           mst_rdata;
  logic [1:0]              mst_rresp;
  logic                    mst_rlast;
  logic [IDW-1:0]          slv_arid;
  logic [AW-1:0]           slv_araddr;
  logic [7:0]              slv_arlen;
  logic [2:0]              slv_arsize;
  logic [1:0]              slv_arburst;
  logic                    slv_arlock;
  logic [3:0]              slv_arcache;
  logic [2:0]              slv_arprot;
  logic [3:0]              slv_arqos;
  logic                    slv_arvalid, slv_arready;
  logic [IDW-1:0]          slv_rid;
  logic [DW-1:0]           slv_rdata;
  logic [1:0]              slv_rresp;
  logic                    slv_rlast, slv_rvalid, slv_rready;
  logic                    rd_id_err;

  axi4_m2s_read_arbiter #(
    .AXI_ID_WIDTH_P(IDW), .AXI_ADDR_WIDTH_P(AW), .AXI_DATA_WIDTH_P(DW), .NR_OF_MASTERS_P(N)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mst_arid(mst_arid), .mst_araddr(mst_araddr), .mst_arlen(mst_arlen),
    .mst_arvalid(mst_arvalid), .mst_arready(mst_arready),
    .mst_rid(mst_rid), .mst_rdata(mst_rdata), .mst_rresp(mst_rresp), .mst_rlast(mst_rlast),
    .mst_rvalid(mst_rvalid), .mst_rready(mst_rready),
    .slv_arid(slv_arid), .slv_araddr(slv_araddr), .slv_arlen(slv_arlen),
    .slv_arsize(slv_arsize), .slv_arburst(slv_arburst), .slv_arlock(slv_arlock),
    .slv_arcache(slv_arcache), .slv_arprot(slv_arprot), .slv_arqos(slv_arqos),
    .slv_arvalid(slv_arvalid), .slv_arready(slv_arready),
    .slv_rid(slv_rid), .slv_rdata(slv_rdata), .slv_rresp(slv_rresp), .slv_rlast(slv_rlast),
    .slv_rvalid(slv_rvalid), .slv_rready(slv_rready),
    .rd_id_err(rd_id_err)
  );

  typedef struct {int m; logic [IDW-1:0] id; logic [AW-1:0] addr; logic [7:0] len;} ar_t;
  typedef struct {int m; logic [DW-1:0] data; logic last;} r_t;

  ar_t exp_ar[$];
  r_t  exp_r[$];
  int  chk_cnt  = 0;
  int  pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- master AR drivers ----------------
  int           pending [N] = '{default: 0};
  logic [0:N-1] drv_h;

  initial forever begin
    @(negedge clk);
    drv_h = mst_arvalid & mst_arready;
    @(posedge clk);
    #1;
    for (int m = 0; m < N; m++) begin
      if (drv_h[m]) begin
        pending[m]--;
        mst_arvalid[m] = (pending[m] > 0);
      end
    end
  end

  // ---------------- slave model: rdata = araddr + beat ----------------
  int             ar_stall = 0;
  bit             bad_rid  = 1'b0;
  bit             s_rst, s_ar, s_r;
  logic [AW-1:0]  s_base;
  logic [7:0]     s_len, s_beat;
  logic [IDW-1:0] s_id;

  initial begin
    slv_arready = 1'b1; slv_rvalid = 1'b0; slv_rid = '0;
    slv_rdata = '0; slv_rresp = 2'b00; slv_rlast = 1'b0;
    forever begin
      @(negedge clk);
      s_rst = !rst_n;
      s_ar  = slv_arvalid && slv_arready;
      s_r   = slv_rvalid && slv_rready;
      if (s_ar) begin
        s_base = slv_araddr; s_len = slv_arlen; s_id = slv_arid;
      end
      if (slv_arvalid && ar_stall > 0) ar_stall--;
      @(posedge clk);
      #1;
      if (s_rst) begin
        slv_rvalid = 1'b0; slv_rlast = 1'b0;
      end else if (s_ar) begin
        s_beat = 8'd0; slv_rvalid = 1'b1; slv_rdata = s_base;
        slv_rid = bad_rid ? 3'd6 : s_id; slv_rlast = (s_len == 8'd0);
      end else if (s_r) begin
        if (slv_rlast) begin
          slv_rvalid = 1'b0; slv_rlast = 1'b0;
        end else begin
          s_beat++;
          slv_rdata = s_base + AW'(s_beat); slv_rid = s_id; slv_rlast = (s_beat == s_len);
        end
      end
      slv_arready = (ar_stall == 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int           cyc = 0, last_rlast = -100, bursts_open = 0;
  int           r_beats = 0, err_cycles = 0, stall_cycles = 0;
  logic         prev_arv = 1'b0;
  ar_t          mon_ar;
  r_t           mon_r;
  logic [0:N-1] mon_oh;
  logic [16:0]  attr_exp = {2'b01, 3'd2, 1'b0, 4'd0, 3'd0, 4'd0};

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rd_id_err) err_cycles++;
    if (slv_arvalid && !prev_arv) check("ar_gap", 64'((cyc - last_rlast) >= 2), 1);
    prev_arv = slv_arvalid;
    if (slv_arvalid && !slv_arready) begin
      stall_cycles++;
      check("ar_stall_ready", 64'(mst_arready), 0);
    end
    if (slv_arvalid && slv_arready) begin
      if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
      else begin
        mon_ar = exp_ar.pop_front();
        mon_oh = '0; mon_oh[mon_ar.m] = 1'b1;
        $display("AR  t=%0d master=%0d id=%0d addr=0x%0h len=%0d", cyc, mon_ar.m, slv_arid, slv_araddr, slv_arlen);
        check("ar_grant", 64'(mst_arready), 64'(mon_oh));
        check("ar_addr", 64'(slv_araddr), 64'(mon_ar.addr));
        check("ar_len", 64'(slv_arlen), 64'(mon_ar.len));
        check("ar_id", 64'(slv_arid), 64'(mon_ar.id));
        check("ar_attr", 64'({slv_arburst, slv_arsize, slv_arlock, slv_arcache, slv_arprot, slv_arqos}), 64'(attr_exp));
        check("ar_overlap", 64'(bursts_open), 0);
        bursts_open++;
      end
    end
    if (|(mst_rvalid & mst_rready)) begin
      r_beats++;
      if (exp_r.size() == 0) check("r_unexpected", 1, 0);
      else begin
        mon_r = exp_r.pop_front();
        mon_oh = '0; mon_oh[mon_r.m] = 1'b1;
        $display("R   t=%0d master=%0d data=0x%0h last=%0d", cyc, mon_r.m, mst_rdata, mst_rlast);
        check("r_route", 64'(mst_rvalid), 64'(mon_oh));
        check("r_data", 64'(mst_rdata), 64'(mon_r.data));
        check("r_last", 64'(mst_rlast), 64'(mon_r.last));
      end
      if (mst_rlast) begin
        bursts_open--;
        last_rlast = cyc;
      end
    end
    if (!rst_n) bursts_open = 0;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int m, input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    mst_arid[m] = id; mst_araddr[m] = addr; mst_arlen[m] = len;
    pending[m]++;
    mst_arvalid[m] = 1'b1;
    exp_ar.push_back('{m, id, addr, len});
    for (int b = 0; b <= int'(len); b++) exp_r.push_back('{m, addr + AW'(b), b == int'(len)});
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_ar.size() != 0 || exp_r.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({"done_", name}, 64'(exp_ar.size() == 0 && exp_r.size() == 0), 1);
    tick();
  endtask

  task automatic wait_beats(input string name, input int target, input int budget);
    int n = 0;
    while (r_beats < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({"beats_", name}, 64'(r_beats >= target), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, 64'(slv_arvalid), 0);
    check({tag, "_arready"}, 64'(mst_arready), 0);
    check({tag, "_rvalid"},  64'(mst_rvalid), 0);
    check({tag, "_rready"},  64'(slv_rready), 0);
    check({tag, "_araddr"},  64'({slv_araddr, slv_arid, slv_arlen}), 0);
    check({tag, "_iderr"},   64'(rd_id_err), 0);
  endtask

  int start_beats, start_stall, start_err, exp_err;

  initial begin
    rst_n = 1'b0;
    mst_arvalid = '0; mst_rready = '1;
    mst_arid = '0; mst_araddr = '0; mst_arlen = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // single master 2, 4 beats, grant latency of one cycle
    issue(2, 3'd2, 32'h100, 8'd3);
    @(negedge clk);
    check("lat_before", 64'(slv_arvalid), 0);
    @(negedge clk);
    check("lat_after", 64'(slv_arvalid), 1);
    wait_idle("single", 50);
    @(negedge clk);
    check("single_idle", 64'({slv_rready, mst_rvalid, slv_arvalid}), 0);
    tick();

    // reset so rr_ptr starts at 0, then all four masters contend
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    issue(0, 3'd1, 32'h1000, 8'd1);
    issue(1, 3'd2, 32'h2000, 8'd1);
    issue(2, 3'd3, 32'h3000, 8'd1);
    issue(3, 3'd4, 32'h4000, 8'd1);
    issue(0, 3'd1, 32'h1000, 8'd1);
    wait_idle("rr4", 200);

    // slave AR backpressure for 5 cycles
    start_stall = stall_cycles;
    ar_stall = 5;
    slv_arready = 1'b0;
    issue(1, 3'd5, 32'h5000, 8'd0);
    wait_idle("stall", 50);
    check("stall_cycles", 64'(stall_cycles - start_stall), 5);

    // master R backpressure for 3 cycles mid-burst
    start_beats = r_beats;
    issue(0, 3'd6, 32'h6000, 8'd7);
    wait_beats("rbp", start_beats + 2, 50);
    tick();
    mst_rready[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rbp_slv_rready", 64'(slv_rready), 0);
    end
    tick();
    mst_rready[0] = 1'b1;
    wait_idle("rbp", 50);
    check("rbp_beat_count", 64'(r_beats - start_beats), 8);

    // reset during beat 2 of an 8-beat burst, then a fresh grant
    start_beats = r_beats;
    issue(1, 3'd7, 32'h7000, 8'd7);
    wait_beats("rst", start_beats + 2, 50);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    exp_r.delete();
    check("midrst_ar_empty", 64'(exp_ar.size()), 0);
    tick();
    issue(2, 3'd2, 32'h8000, 8'd0);
    wait_idle("after_rst", 50);

    // wrong R ID returned on beat 0
    start_err = err_cycles;
    bad_rid = 1'b1;
    issue(3, 3'd5, 32'h9000, 8'd1);
    wait_idle("iderr", 50);
    bad_rid = 1'b0;
    tick();
    tick();
`ifdef AXI4_M2S_RD_ARB_ID_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    check("id_err_cycles", 64'(err_cycles - start_err), 64'(exp_err));
    check("final_queues", 64'(exp_ar.size() + exp_r.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
